// File: rtl/subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed so checkers can probe the FSM by value.
package subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bit_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module bit_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Result registers only change on the completing edge, so they hold between operations.
module serial_subtractor
   import subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Handshake: start is accepted on any edge where the FSM is IDLE (busy=0),
   // including the done cycle; busy is high from that edge until done, and done
   // is a one-cycle pulse on which diff/borrow_out/overflow become valid.
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             br;
   logic [WIDTH-1:0] sreg;
   logic             d_bit;
   logic             bout_bit;
   logic [WIDTH-1:0] shifted;

   bit_subtractor_cell u_cell (
      .a    (a_q[cnt]),
      .b    (b_q[cnt]),
      .bin  (br),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign shifted = {d_bit, sreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         br         <= 1'b0;
         sreg       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  br    <= borrow_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sreg <= shifted;
               br   <= bout_bit;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // The MSB is processed last, so d_bit is the result sign here.
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  diff       <= shifted;
                  borrow_out <= bout_bit;
                  overflow   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d_bit != a_q[WIDTH-1]);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) using an expected-result queue.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         overflow;

   int checks = 0;
   int errors = 0;
   logic [W+1:0] exp_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   // Reference: {diff, borrow_out, overflow} from a full-width subtraction.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbin);
      logic [W:0] full;
      logic       ovf;
      full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      ovf  = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
      return {full[W-1:0], full[W], ovf};
   endfunction

   task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
      a         = ta;
      b         = tb_;
      borrow_in = tbin;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      borrow_in = 1'($urandom);
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b done=%b exp 0 0", busy, done);
      end
      checks++;
      if ({diff, borrow_out, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_result got %h/%b/%b exp 00/0/0", diff, borrow_out, overflow);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] ta[4]  = '{8'h05, 8'h03, 8'h80, 8'h00};
      logic [W-1:0] tb_[4] = '{8'h03, 8'h05, 8'h01, 8'h00};
      logic         tbin[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] va, vb;
      logic         vbin;
      logic [W+1:0] e;
      int           cyc;
      bit           ok;
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin
            va = ta[i]; vb = tb_[i]; vbin = tbin[i];
         end else begin
            va = W'($urandom_range(0, 255));
            vb = W'($urandom_range(0, 255));
            vbin = 1'($urandom_range(0, 1));
         end
         exp_q.push_back(model(va, vb, vbin));
         drive_start(va, vb, vbin);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1", busy);
         end
         wait_done(cyc, ok);
         checks++;
         if (!ok || cyc != W) begin
            errors++;
            $display("FAIL basic_latency got %0d (done=%b) exp %0d", cyc, ok, W);
         end
         e = exp_q.pop_front();
         checks++;
         if ({diff, borrow_out, overflow} !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result a=%h b=%h bin=%b got %h/%b/%b busy=%b exp %h/%b/%b busy=0",
                     va, vb, vbin, diff, borrow_out, overflow, busy, e[W+1:2], e[1], e[0]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || {diff, borrow_out, overflow} !== e) begin
            errors++;
            $display("FAIL basic_hold got done=%b %h/%b/%b exp done=0 %h/%b/%b",
                     done, diff, borrow_out, overflow, e[W+1:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [W+1:0] e;
      int           cyc;
      int           pulses;
      bit           ok;
      exp_q.push_back(model(8'h5A, 8'h33, 1'b0));
      drive_start(8'h5A, 8'h33, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      a = 8'hE1; b = 8'h7F; borrow_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc != W - 3) begin
         errors++;
         $display("FAIL ignore_latency got %0d (done=%b) exp %0d", cyc, ok, W - 3);
      end
      e = exp_q.pop_front();
      checks++;
      if ({diff, borrow_out, overflow} !== e) begin
         errors++;
         $display("FAIL ignore_result got %h/%b/%b exp %h/%b/%b",
                  diff, borrow_out, overflow, e[W+1:2], e[1], e[0]);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_extra_done got %0d pulses busy=%b exp 0 pulses busy=0", pulses, busy);
      end
   endtask

   task automatic test_abort();
      int pulses;
      drive_start(8'h77, 8'h11, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {diff, borrow_out, overflow} !== '0) begin
         errors++;
         $display("FAIL abort_clear got busy=%b done=%b %h/%b/%b exp all 0",
                  busy, done, diff, borrow_out, overflow);
      end
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d pulses exp 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      logic [W+1:0] e1, e2;
      int           cyc;
      bit           ok;
      exp_q.push_back(model(8'hC8, 8'h3D, 1'b1));
      exp_q.push_back(model(8'h10, 8'h20, 1'b0));
      drive_start(8'hC8, 8'h3D, 1'b1);
      wait_done(cyc, ok);
      e1 = exp_q.pop_front();
      checks++;
      if (!ok || cyc != W || {diff, borrow_out, overflow} !== e1) begin
         errors++;
         $display("FAIL b2b_first got cyc=%0d %h/%b/%b exp cyc=%0d %h/%b/%b",
                  cyc, diff, borrow_out, overflow, W, e1[W+1:2], e1[1], e1[0]);
      end
      drive_start(8'h10, 8'h20, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept got busy=%b exp 1", busy);
      end
      for (int i = 1; i < W; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || {diff, borrow_out, overflow} !== e1) begin
            errors++;
            $display("FAIL b2b_hold cycle %0d got done=%b %h/%b/%b exp done=0 %h/%b/%b",
                     i, done, diff, borrow_out, overflow, e1[W+1:2], e1[1], e1[0]);
         end
      end
      @(posedge clk);
      #1;
      e2 = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || {diff, borrow_out, overflow} !== e2) begin
         errors++;
         $display("FAIL b2b_second got done=%b %h/%b/%b exp done=1 %h/%b/%b",
                  done, diff, borrow_out, overflow, e2[W+1:2], e2[1], e2[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..64.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The module SHALL have port a, input, WIDTH bits: minuend.
REQ-006 The module SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 The module SHALL have port borrow_in, input, 1 bit: borrow into bit 0.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 The module SHALL have port diff, output, WIDTH bits: the registered result a - b - borrow_in, modulo 2^WIDTH.
REQ-011 The module SHALL have port borrow_out, output, 1 bit: borrow out of the MSB (unsigned a < b + borrow_in).
REQ-012 The module SHALL have port overflow, output, 1 bit: signed two's-complement overflow of the result.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN, plus a bit counter of width $clog2(WIDTH).
REQ-014 In IDLE with start=1, the block SHALL latch a, b and borrow_in, clear the counter, and enter RUN; busy SHALL rise at that same edge.
REQ-015 In RUN, each clock SHALL process one bit, LSB first.
- Bit process: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
- d SHALL shift into diff from the MSB side, so that after WIDTH shifts bit 0 sits at diff[0].
REQ-016 On the WIDTH-th RUN edge, the block SHALL return to IDLE, set done=1, set busy=0, and update borrow_out and overflow.
- Latency: done SHALL be high exactly WIDTH cycles after the edge that accepted start.
REQ-017 overflow SHALL equal (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]), using the latched a and b.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 diff, borrow_out and overflow SHALL hold their values from the done cycle until the next accepted start completes.
- During RUN, diff MAY show partial shift contents; only the done cycle defines validity.
REQ-020 start SHALL be ignored while in RUN; the latched operands SHALL stay unchanged.
REQ-021 start=1 in the done cycle (state IDLE) SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-022 Changes on a, b or borrow_in after the accepting edge SHALL NOT affect the result.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set:
- state=IDLE, counter=0;
- busy=0, done=0;
- diff=0, borrow_out=0, overflow=0;
- internal operand and borrow registers=0.
REQ-024 rst SHALL take priority over start and abort any RUN operation; no done pulse SHALL follow an aborted operation.

Structure
REQ-025 Package subtractor_pkg SHALL hold the state encoding (IDLE=0, RUN=1) and the default WIDTH constant.
REQ-026 The one-bit full-subtract function SHALL be a combinational sub-module, bit_subtractor_cell (ports a, b, bin, d, bout), instantiated once.
REQ-027 All outputs SHALL be driven directly from registers.

Verification (WIDTH=8)
REQ-028 Start with a=0x05, b=0x03, borrow_in=0 -> after 8 cycles: done=1, diff=0x02, borrow_out=0, overflow=0.
REQ-029 Start with a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0; then a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
REQ-030 Start with a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0.
REQ-031 Start at cycle 3 of RUN with different operands -> ignored; the original result is produced with exactly one done pulse.
REQ-032 Assert rst at cycle 4 of RUN -> next cycle busy=0 and all outputs 0; no done pulse follows.
REQ-033 Assert start in the done cycle -> the second result appears with done exactly 8 cycles later; the first result holds in between.
